// File: rtl/ysyx_22041211_sram_arb_pkg.sv
// Shared types for the IFU/LSU data-SRAM arbiter: FSM states, owner id and IFU read mask.
package ysyx_22041211_sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [7:0] IFU_RMASK = 8'h0F;

endpackage

// File: rtl/ysyx_22041211_rr_arb2.sv
// Two-way round-robin grant; the requester that did not win last time wins a tie.
module ysyx_22041211_rr_arb2
  import ysyx_22041211_sram_arb_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  logic last_lsu;

  always_comb begin
    last_lsu = (last_grant == OWN_LSU);
    gnt_ifu  = ifu_valid && (!lsu_valid || last_lsu);
    gnt_lsu  = lsu_valid && (!ifu_valid || !last_lsu);
  end

endmodule

// File: rtl/ysyx_22041211_sram_arbiter.sv
// Shares one data-SRAM port between IFU (reads) and LSU (reads/writes), one transaction at a time.
module ysyx_22041211_sram_arbiter
  import ysyx_22041211_sram_arb_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int LAT      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_LEN-1:0] ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_LEN-1:0] ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_LEN-1:0] lsu_addr,
  input  logic [DATA_LEN-1:0] lsu_wdata,
  input  logic [7:0]          lsu_wmask,
  input  logic [7:0]          lsu_rmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_LEN-1:0] lsu_rdata,
  output logic                sram_ren,
  output logic                sram_wen,
  output logic [ADDR_LEN-1:0] sram_raddr,
  output logic [ADDR_LEN-1:0] sram_waddr,
  output logic [DATA_LEN-1:0] sram_wdata,
  output logic [7:0]          sram_wmask,
  output logic [7:0]          sram_rmask,
  input  logic [DATA_LEN-1:0] sram_rdata
);

  localparam int CNT_W = $clog2(LAT) + 1;

  state_t              state_q;
  owner_t              owner_q;
  owner_t              last_grant_q;
  owner_t              nxt_owner;
  logic                wen_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [7:0]          wmask_q;
  logic [7:0]          rmask_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_LEN-1:0] ifu_rdata_q;
  logic [DATA_LEN-1:0] lsu_rdata_q;
  logic                gnt_ifu;
  logic                gnt_lsu;
  logic                idle;
  logic                access;
  logic                rsp_done;

  ysyx_22041211_rr_arb2 u_rr_arb2 (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant_q),
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu)
  );

  // Enables and readies are masked by rst so a reset cycle never touches the SRAM or accepts work.
  assign idle          = (state_q == IDLE) && !rst;
  assign access        = (state_q == ACCESS) && !rst;
  assign ifu_req_ready = idle && gnt_ifu;
  assign lsu_req_ready = idle && gnt_lsu;
  assign sram_ren      = access && !wen_q;
  assign sram_wen      = access && wen_q;
  assign sram_raddr    = addr_q;
  assign sram_waddr    = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_wmask    = wmask_q;
  assign sram_rmask    = rmask_q;
  assign ifu_rsp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign rsp_done      = (owner_q == OWN_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

  always_comb begin
    nxt_owner = OWN_IFU;
    if (gnt_lsu) nxt_owner = OWN_LSU;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rmask_q      <= '0;
      cnt_q        <= '0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_ifu || gnt_lsu) begin
            owner_q      <= nxt_owner;
            last_grant_q <= nxt_owner;
            wen_q        <= gnt_lsu && lsu_wen;
            addr_q       <= gnt_lsu ? lsu_addr : ifu_addr;
            wdata_q      <= gnt_lsu ? lsu_wdata : '0;
            wmask_q      <= gnt_lsu ? lsu_wmask : 8'h00;
            rmask_q      <= gnt_lsu ? lsu_rmask : IFU_RMASK;
            cnt_q        <= CNT_W'(LAT - 1);
            if (LAT > 1) state_q <= WAIT;
            else         state_q <= ACCESS;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ACCESS;
        end
        ACCESS: begin
          if (owner_q == OWN_IFU) ifu_rdata_q <= wen_q ? '0 : sram_rdata;
          else                    lsu_rdata_q <= wen_q ? '0 : sram_rdata;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_sram_arbiter.sv
// Bench for the SRAM arbiter: one instance at LAT=1 and one at LAT=3, each with a small SRAM model.
module tb_ysyx_22041211_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ifu_req_valid[2], ifu_req_ready[2], ifu_rsp_valid[2], ifu_rsp_ready[2];
  logic [31:0] ifu_addr[2], ifu_rdata[2];
  logic        lsu_req_valid[2], lsu_req_ready[2], lsu_wen[2], lsu_rsp_valid[2], lsu_rsp_ready[2];
  logic [31:0] lsu_addr[2], lsu_wdata[2], lsu_rdata[2];
  logic [7:0]  lsu_wmask[2], lsu_rmask[2];
  logic        sram_ren[2], sram_wen[2];
  logic [31:0] sram_raddr[2], sram_waddr[2], sram_wdata[2], sram_rdata[2];
  logic [7:0]  sram_wmask[2], sram_rmask[2];

  logic [31:0] mem[2][16];
  logic [31:0] ref_mem[2][16];
  logic        bk_we;
  int          bk_d;
  logic [3:0]  bk_idx;
  logic [31:0] bk_data;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_22041211_sram_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .LAT(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid[g]), .ifu_req_ready(ifu_req_ready[g]), .ifu_addr(ifu_addr[g]),
      .ifu_rsp_valid(ifu_rsp_valid[g]), .ifu_rsp_ready(ifu_rsp_ready[g]), .ifu_rdata(ifu_rdata[g]),
      .lsu_req_valid(lsu_req_valid[g]), .lsu_req_ready(lsu_req_ready[g]), .lsu_wen(lsu_wen[g]),
      .lsu_addr(lsu_addr[g]), .lsu_wdata(lsu_wdata[g]), .lsu_wmask(lsu_wmask[g]), .lsu_rmask(lsu_rmask[g]),
      .lsu_rsp_valid(lsu_rsp_valid[g]), .lsu_rsp_ready(lsu_rsp_ready[g]), .lsu_rdata(lsu_rdata[g]),
      .sram_ren(sram_ren[g]), .sram_wen(sram_wen[g]), .sram_raddr(sram_raddr[g]), .sram_waddr(sram_waddr[g]),
      .sram_wdata(sram_wdata[g]), .sram_wmask(sram_wmask[g]), .sram_rmask(sram_rmask[g]),
      .sram_rdata(sram_rdata[g])
    );
    // Garbage when not enabled so a capture outside the access cycle shows up.
    assign sram_rdata[g] = sram_ren[g] ? mem[g][sram_raddr[g][5:2]] : 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (bk_we) mem[bk_d][bk_idx] <= bk_data;
    for (int d = 0; d < 2; d++)
      if (sram_wen[d])
        for (int b = 0; b < 4; b++)
          if (sram_wmask[d][b]) mem[d][sram_waddr[d][5:2]][8*b +: 8] <= sram_wdata[d][8*b +: 8];
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      ifu_req_valid[d] = 1'b0; ifu_addr[d] = '0; ifu_rsp_ready[d] = 1'b0;
      lsu_req_valid[d] = 1'b0; lsu_wen[d] = 1'b0; lsu_addr[d] = '0; lsu_wdata[d] = '0;
      lsu_wmask[d] = '0; lsu_rmask[d] = '0; lsu_rsp_ready[d] = 1'b0;
    end
  endtask

  task automatic poke(input int d, input int i, input logic [31:0] v);
    tick();
    bk_we = 1'b1; bk_d = d; bk_idx = 4'(i); bk_data = v;
    ref_mem[d][i] = v;
    tick();
    bk_we = 1'b0;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); tick(); rst = 1'b0;
  endtask

  // Drives one request and checks the whole transaction against the timing rules:
  // SRAM access at accept+LAT, response from accept+LAT+1 until the handshake.
  task automatic do_txn(input int d, input bit lsu, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [7:0] wm, input logic [7:0] rm, input int hold);
    int L, w, idx;
    logic [31:0] exp;
    logic own_v, oth_v, own_rdy, oth_rdy;
    L = lat_of(d);
    idx = int'(a[5:2]);
    exp = wr ? 32'h0 : ref_mem[d][idx];
    tick();
    if (lsu) begin
      lsu_req_valid[d] = 1'b1; lsu_wen[d] = wr; lsu_addr[d] = a;
      lsu_wdata[d] = wd; lsu_wmask[d] = wm; lsu_rmask[d] = rm;
    end else begin
      ifu_req_valid[d] = 1'b1; ifu_addr[d] = a;
    end
    #1;
    w = 0;
    while (((lsu ? lsu_req_ready[d] : ifu_req_ready[d]) !== 1'b1) && w < 20) begin
      tick(); #1; w++;
    end
    checks++;
    if (w >= 20) begin
      errors++;
      $display("FAIL accept_timeout d=%0d lsu=%0d waited %0d cycles, required ready", d, lsu, w);
      ifu_req_valid[d] = 1'b0; lsu_req_valid[d] = 1'b0;
      return;
    end
    oth_rdy = lsu ? ifu_req_ready[d] : lsu_req_ready[d];
    checks++;
    if (oth_rdy !== 1'b0) begin
      errors++; $display("FAIL other_ready d=%0d got %b want 0", d, oth_rdy);
    end
    for (int k = 1; k <= L + 1 + hold; k++) begin
      tick();
      ifu_req_valid[d] = 1'b0; lsu_req_valid[d] = 1'b0;
      if (lsu) begin lsu_rsp_ready[d] = (k >= L + 1 + hold); ifu_rsp_ready[d] = 1'($urandom); end
      else     begin ifu_rsp_ready[d] = (k >= L + 1 + hold); lsu_rsp_ready[d] = 1'($urandom); end
      #1;
      checks++;
      if ({sram_ren[d], sram_wen[d]} !== {k == L && !wr, k == L && wr}) begin
        errors++;
        $display("FAIL sram_enables d=%0d k=%0d got ren/wen %b%b want %b%b", d, k,
                 sram_ren[d], sram_wen[d], k == L && !wr, k == L && wr);
      end
      if (k == L && wr) begin
        checks++;
        if ({sram_waddr[d], sram_wdata[d], sram_wmask[d]} !== {a, wd, wm}) begin
          errors++;
          $display("FAIL write_port d=%0d got %h %h %h want %h %h %h", d,
                   sram_waddr[d], sram_wdata[d], sram_wmask[d], a, wd, wm);
        end
      end
      if (k == L && !wr) begin
        checks++;
        if ({sram_raddr[d], sram_rmask[d]} !== {a, lsu ? rm : 8'h0F}) begin
          errors++;
          $display("FAIL read_port d=%0d got %h %h want %h %h", d, sram_raddr[d], sram_rmask[d],
                   a, lsu ? rm : 8'h0F);
        end
      end
      own_v = lsu ? lsu_rsp_valid[d] : ifu_rsp_valid[d];
      oth_v = lsu ? ifu_rsp_valid[d] : lsu_rsp_valid[d];
      checks++;
      if (own_v !== (k >= L + 1) || oth_v !== 1'b0) begin
        errors++;
        $display("FAIL rsp_valid d=%0d k=%0d got own=%b other=%b want own=%b other=0", d, k, own_v, oth_v, k >= L + 1);
      end
      if (k >= L + 1) begin
        checks++;
        if ((lsu ? lsu_rdata[d] : ifu_rdata[d]) !== exp) begin
          errors++;
          $display("FAIL rsp_rdata d=%0d k=%0d got %h want %h", d, k, lsu ? lsu_rdata[d] : ifu_rdata[d], exp);
        end
      end
    end
    tick();
    ifu_rsp_ready[d] = 1'b0; lsu_rsp_ready[d] = 1'b0;
    #1;
    checks++;
    if ({ifu_rsp_valid[d], lsu_rsp_valid[d]} !== 2'b00) begin
      errors++;
      $display("FAIL rsp_release d=%0d got %b%b want 00", d, ifu_rsp_valid[d], lsu_rsp_valid[d]);
    end
    if (wr)
      for (int b = 0; b < 4; b++)
        if (wm[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin ifu_req_valid[d] = 1'b1; lsu_req_valid[d] = 1'b1; end
    tick(); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ifu_req_ready[d], lsu_req_ready[d], sram_ren[d], sram_wen[d]} !== 4'b0) begin
        errors++;
        $display("FAIL reset_ready d=%0d got %b%b%b%b want 0000", d, ifu_req_ready[d], lsu_req_ready[d],
                 sram_ren[d], sram_wen[d]);
      end
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ifu_rsp_valid[d], lsu_rsp_valid[d], sram_ren[d], sram_wen[d]} !== 4'b0) begin
        errors++; $display("FAIL reset_ctrl d=%0d got nonzero control outputs", d);
      end
      checks++;
      if ({sram_raddr[d], sram_waddr[d], sram_wdata[d], sram_wmask[d], sram_rmask[d]} !== 112'b0) begin
        errors++;
        $display("FAIL reset_sram d=%0d got %h %h %h %h %h want all 0", d, sram_raddr[d], sram_waddr[d],
                 sram_wdata[d], sram_wmask[d], sram_rmask[d]);
      end
      checks++;
      if ({ifu_rdata[d], lsu_rdata[d]} !== 64'b0) begin
        errors++; $display("FAIL reset_rdata d=%0d got %h %h want 0 0", d, ifu_rdata[d], lsu_rdata[d]);
      end
    end
  endtask

  task automatic test_ifu_read();
    for (int d = 0; d < 2; d++) begin
      poke(d, 0, 32'h0000_0413);
      do_txn(d, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h0, 8'h0, 0);
      repeat (4) do_txn(d, 1'b0, 1'b0, rand_addr(), 32'h0, 8'h0, 8'h0, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_lsu_write();
    for (int d = 0; d < 2; d++) begin
      do_txn(d, 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 8'h00, 0);
      do_txn(d, 1'b1, 1'b0, 32'h8000_1000, 32'h0, 8'h00, 8'h0F, 0);
      repeat (8) do_txn(d, 1'b1, 1'($urandom), rand_addr(), $urandom, 8'($urandom), 8'($urandom),
                        int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_round_robin(input int d);
    int L, n, last_acc, cur;
    bit exp_lsu;
    logic [31:0] ia, la, got;
    L = lat_of(d); n = 0; last_acc = -100; cur = -1; exp_lsu = 1'b0;
    ia = rand_addr(); la = rand_addr();
    do_reset();
    tick();
    ifu_req_valid[d] = 1'b1; ifu_addr[d] = ia; ifu_rsp_ready[d] = 1'b1;
    lsu_req_valid[d] = 1'b1; lsu_wen[d] = 1'b0; lsu_addr[d] = la; lsu_rmask[d] = 8'hFF; lsu_rsp_ready[d] = 1'b1;
    #1;
    for (int c = 0; c < 60 && n < 6; c++) begin
      if (ifu_req_ready[d] === 1'b1 || lsu_req_ready[d] === 1'b1) begin
        checks++;
        if ({ifu_req_ready[d], lsu_req_ready[d]} !== (exp_lsu ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL rr_grant d=%0d n=%0d got %b%b want lsu=%0d", d, n, ifu_req_ready[d], lsu_req_ready[d], exp_lsu);
        end
        if (n > 0) begin
          checks++;
          if (c - last_acc != L + 2) begin
            errors++; $display("FAIL rr_gap d=%0d got %0d want %0d", d, c - last_acc, L + 2);
          end
        end
        cur = exp_lsu ? 1 : 0; last_acc = c; exp_lsu = !exp_lsu; n++;
      end
      checks++;
      if ({ifu_rsp_valid[d], lsu_rsp_valid[d]} !== {cur == 0 && c == last_acc + L + 1, cur == 1 && c == last_acc + L + 1}) begin
        errors++;
        $display("FAIL rr_rsp_route d=%0d c=%0d got %b%b owner=%0d", d, c, ifu_rsp_valid[d], lsu_rsp_valid[d], cur);
      end
      if (c == last_acc + L + 1) begin
        got = (cur == 0) ? ifu_rdata[d] : lsu_rdata[d];
        checks++;
        if (got !== ref_mem[d][(cur == 0) ? int'(ia[5:2]) : int'(la[5:2])]) begin
          errors++;
          $display("FAIL rr_rdata d=%0d got %h want %h", d, got, ref_mem[d][(cur == 0) ? int'(ia[5:2]) : int'(la[5:2])]);
        end
      end
      tick(); #1;
    end
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL rr_count d=%0d got %0d grants want 6", d, n);
    end
    ifu_req_valid[d] = 1'b0; lsu_req_valid[d] = 1'b0;
    repeat (L + 3) tick();
    ifu_rsp_ready[d] = 1'b0; lsu_rsp_ready[d] = 1'b0;
  endtask

  // LAT=3: LSU response held off for 4 cycles while the IFU waits for the bus.
  task automatic test_busy_block();
    int w, hold;
    logic [31:0] a, b;
    hold = 4; a = rand_addr(); b = rand_addr();
    tick();
    lsu_req_valid[1] = 1'b1; lsu_wen[1] = 1'b0; lsu_addr[1] = a; lsu_rmask[1] = 8'hF0;
    #1;
    w = 0;
    while (lsu_req_ready[1] !== 1'b1 && w < 20) begin tick(); #1; w++; end
    checks++;
    if (w >= 20) begin errors++; $display("FAIL busy_accept_timeout waited %0d cycles", w); end
    for (int k = 1; k <= 4 + hold; k++) begin
      tick();
      lsu_req_valid[1] = 1'b0;
      ifu_req_valid[1] = 1'b1; ifu_addr[1] = b;
      lsu_rsp_ready[1] = (k >= 4 + hold);
      #1;
      checks++;
      if (ifu_req_ready[1] !== 1'b0) begin
        errors++; $display("FAIL busy_ifu_ready k=%0d got %b want 0", k, ifu_req_ready[1]);
      end
      checks++;
      if (lsu_rsp_valid[1] !== (k >= 4)) begin
        errors++; $display("FAIL busy_rsp_valid k=%0d got %b want %b", k, lsu_rsp_valid[1], k >= 4);
      end
      if (k >= 4) begin
        checks++;
        if (lsu_rdata[1] !== ref_mem[1][int'(a[5:2])]) begin
          errors++; $display("FAIL busy_rdata k=%0d got %h want %h", k, lsu_rdata[1], ref_mem[1][int'(a[5:2])]);
        end
      end
    end
    tick();
    lsu_rsp_ready[1] = 1'b0;
    #1;
    checks++;
    if ({ifu_req_ready[1], lsu_rsp_valid[1]} !== 2'b10) begin
      errors++; $display("FAIL busy_after_hs got ready=%b lsu_v=%b want 1 0", ifu_req_ready[1], lsu_rsp_valid[1]);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      ifu_req_valid[1] = 1'b0;
      ifu_rsp_ready[1] = (k == 4);
      #1;
      checks++;
      if (ifu_rsp_valid[1] !== (k == 4)) begin
        errors++; $display("FAIL busy_ifu_rsp k=%0d got %b want %b", k, ifu_rsp_valid[1], k == 4);
      end
    end
    checks++;
    if (ifu_rdata[1] !== ref_mem[1][int'(b[5:2])]) begin
      errors++; $display("FAIL busy_ifu_rdata got %h want %h", ifu_rdata[1], ref_mem[1][int'(b[5:2])]);
    end
    tick();
    ifu_rsp_ready[1] = 1'b0;
  endtask

  // Reset during WAIT (LAT=3) and during ACCESS (LAT=1) must drop the write entirely.
  task automatic test_reset_mid();
    int w, rk;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      a = 32'h8000_0000 | (32'(5 + d) << 2);
      rk = (d == 0) ? 1 : 2;
      tick();
      lsu_req_valid[d] = 1'b1; lsu_wen[d] = 1'b1; lsu_addr[d] = a;
      lsu_wdata[d] = ~ref_mem[d][5 + d]; lsu_wmask[d] = 8'hFF; lsu_rsp_ready[d] = 1'b1;
      #1;
      w = 0;
      while (lsu_req_ready[d] !== 1'b1 && w < 20) begin tick(); #1; w++; end
      checks++;
      if (w >= 20) begin errors++; $display("FAIL rstmid_accept_timeout d=%0d", d); end
      for (int k = 1; k <= rk; k++) begin
        tick();
        lsu_req_valid[d] = 1'b0;
        rst = (k == rk);
      end
      #1;
      checks++;
      if (sram_wen[d] !== 1'b0) begin
        errors++; $display("FAIL rstmid_wen_in_reset d=%0d got %b want 0", d, sram_wen[d]);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({sram_waddr[d], sram_wdata[d], sram_wmask[d], lsu_rdata[d]} !== 104'b0) begin
        errors++;
        $display("FAIL rstmid_outputs d=%0d got %h %h %h %h want 0", d, sram_waddr[d], sram_wdata[d], sram_wmask[d], lsu_rdata[d]);
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if ({sram_ren[d], sram_wen[d], lsu_rsp_valid[d], ifu_rsp_valid[d]} !== 4'b0) begin
          errors++; $display("FAIL rstmid_quiet d=%0d k=%0d got nonzero enables/valids", d, k);
        end
        tick(); #1;
      end
      lsu_rsp_ready[d] = 1'b0;
      do_txn(d, 1'b1, 1'b0, a, 32'h0, 8'h0, 8'hFF, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bk_we = 1'b0; bk_d = 0; bk_idx = '0; bk_data = '0;
    idle_inputs();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) poke(d, i, $urandom);
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_round_robin(0);
    test_round_robin(1);
    test_busy_block();
    test_reset_mid();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
